// File: rtl/systolic_array_os.sv
// systolic_array_os
// Output-stationary ROWS x COLS signed MAC array computing C = A x B over a
// programmable reduction depth. A/B operand beats enter through a valid/ready
// stream, pass a per-row / per-column skew stage, and propagate right (A) and
// down (B) one PE per cycle. Results drain one C row at a time with
// backpressure.
//
// Optional feature macro: SYSTOLIC_SAT_EN
//   defined   : saturating, sticky accumulators plus the sat_flag output
//   undefined : two's-complement wrapping accumulators, no sat_flag port
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, k_len          begin a tile (IDLE only) with reduction depth k_len
//   in_valid, in_ready    operand beat handshake
//   a_in_bus, b_in_bus    A column k (row i in slice i), B row k (col j in slice j)
//   out_valid, out_ready  result row handshake
//   out_row, out_row_idx  C row and its index
//   out_last              high with the final row
//   busy, done            not-IDLE flag, one-cycle completion pulse
//   sat_flag              per-PE saturation flags, row-major (SYSTOLIC_SAT_EN only)
module systolic_array_os #(
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int K_W    = 9,
  localparam int IDX_W  = $clog2((ROWS > 1) ? ROWS : 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_in_bus,
  input  logic [COLS*DATA_W-1:0] b_in_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_W-1:0]  out_row,
  output logic [IDX_W-1:0]       out_row_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
`ifdef SYSTOLIC_SAT_EN
  , output logic [ROWS*COLS-1:0] sat_flag
`endif
);

  localparam int FLUSH_W = $clog2(ROWS + COLS);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ROWS + COLS - 2);
  localparam logic [IDX_W-1:0]   ROW_LAST   = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Full-precision signed product of one operand pair.
  function automatic logic signed [2*DATA_W-1:0] mul_s(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    return (2*DATA_W)'(a) * (2*DATA_W)'(b);
  endfunction

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One extra bit of headroom so overflow shows as disagreeing top bits.
  function automatic logic signed [ACC_W:0] mac_sum(input logic signed [ACC_W-1:0] acc,
                                                    input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (ACC_W+1)'(acc) + (ACC_W+1)'(mul_s(a, b));
  endfunction
`else
  // Modulo-2^ACC_W accumulate.
  function automatic logic signed [ACC_W-1:0] mac_wrap(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    return acc + ACC_W'(mul_s(a, b));
  endfunction
`endif

  state_t               state_r, state_n;
  logic [K_W-1:0]       k_len_r, k_len_n;
  logic [K_W-1:0]       beat_cnt_r, beat_cnt_n;
  logic [FLUSH_W-1:0]   flush_cnt_r, flush_cnt_n;
  logic [IDX_W-1:0]     row_idx_r, row_idx_n;
  logic                 in_ready_r, out_valid_r, out_last_r, busy_r, done_r, done_n;
  logic                 hs_in_s, hs_out_s, adv_s, clr_s;

  logic signed [DATA_W-1:0] a_beat_s [ROWS];
  logic signed [DATA_W-1:0] b_beat_s [COLS];
  logic signed [DATA_W-1:0] a_skew_s [ROWS];
  logic                     v_skew_s [ROWS];
  logic signed [DATA_W-1:0] b_skew_s [COLS];
  logic signed [DATA_W-1:0] a_pe_s   [ROWS][COLS];
  logic signed [DATA_W-1:0] b_pe_s   [ROWS][COLS];
  logic                     v_pe_s   [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc_s    [ROWS][COLS];

  assign hs_in_s  = in_valid & in_ready_r;
  assign hs_out_s = out_valid_r & out_ready;
  // The array moves only while operands are being loaded or flushed out.
  assign adv_s    = (state_r == ST_LOAD) || (state_r == ST_FLUSH);
  assign clr_s    = (state_r == ST_IDLE) && start;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign out_row_idx = row_idx_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state and counter logic for the tile sequencer.
  always_comb begin
    state_n     = state_r;
    k_len_n     = k_len_r;
    beat_cnt_n  = beat_cnt_r;
    flush_cnt_n = flush_cnt_r;
    row_idx_n   = row_idx_r;
    done_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          k_len_n     = k_len;
          beat_cnt_n  = {K_W{1'b0}};
          flush_cnt_n = {FLUSH_W{1'b0}};
          row_idx_n   = {IDX_W{1'b0}};
          state_n     = (k_len != {K_W{1'b0}}) ? ST_LOAD : ST_FLUSH;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (hs_in_s) begin
          beat_cnt_n = beat_cnt_r + 1'b1;
          if (beat_cnt_n == k_len_r) begin
            state_n = ST_FLUSH;
          end else begin
            state_n = ST_LOAD;
          end
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        // The last beat needs ROWS+COLS-1 advances to reach the far corner PE.
        if (flush_cnt_r == FLUSH_LAST) begin
          flush_cnt_n = {FLUSH_W{1'b0}};
          row_idx_n   = {IDX_W{1'b0}};
          state_n     = ST_DRAIN;
        end else begin
          flush_cnt_n = flush_cnt_r + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (hs_out_s) begin
          if (row_idx_r == ROW_LAST) begin
            row_idx_n = {IDX_W{1'b0}};
            done_n    = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            row_idx_n = row_idx_r + 1'b1;
          end
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_len_r     <= {K_W{1'b0}};
      beat_cnt_r  <= {K_W{1'b0}};
      flush_cnt_r <= {FLUSH_W{1'b0}};
      row_idx_r   <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      k_len_r     <= k_len_n;
      beat_cnt_r  <= beat_cnt_n;
      flush_cnt_r <= flush_cnt_n;
      row_idx_r   <= row_idx_n;
      in_ready_r  <= (state_n == ST_LOAD);
      out_valid_r <= (state_n == ST_DRAIN);
      out_last_r  <= (state_n == ST_DRAIN) && (row_idx_n == ROW_LAST);
      busy_r      <= (state_n != ST_IDLE);
      done_r      <= done_n;
    end
  end

  // Row skew: row i of A (with its valid tag) reaches column 0 i cycles late.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    assign a_beat_s[i] = hs_in_s ? a_in_bus[(i+1)*DATA_W-1 -: DATA_W] : {DATA_W{1'b0}};
    if (i == 0) begin : g_direct
      assign a_skew_s[i] = a_beat_s[i];
      assign v_skew_s[i] = hs_in_s;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sk_r [i];
      logic                     vk_r [i];
      // Shift register delaying A row i and its tag by i cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < i; n++) begin
            sk_r[n] <= {DATA_W{1'b0}};
            vk_r[n] <= 1'b0;
          end
        end else if (clr_s) begin
          for (int n = 0; n < i; n++) begin
            sk_r[n] <= {DATA_W{1'b0}};
            vk_r[n] <= 1'b0;
          end
        end else if (adv_s) begin
          sk_r[0] <= a_beat_s[i];
          vk_r[0] <= hs_in_s;
          for (int n = 1; n < i; n++) begin
            sk_r[n] <= sk_r[n-1];
            vk_r[n] <= vk_r[n-1];
          end
        end
      end
      assign a_skew_s[i] = sk_r[i-1];
      assign v_skew_s[i] = vk_r[i-1];
    end
  end

  // Column skew: column j of B reaches row 0 j cycles late. B needs no tag
  // because it always meets the A operand of the same beat.
  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    assign b_beat_s[j] = hs_in_s ? b_in_bus[(j+1)*DATA_W-1 -: DATA_W] : {DATA_W{1'b0}};
    if (j == 0) begin : g_direct
      assign b_skew_s[j] = b_beat_s[j];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sk_r [j];
      // Shift register delaying B column j by j cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < j; n++) sk_r[n] <= {DATA_W{1'b0}};
        end else if (clr_s) begin
          for (int n = 0; n < j; n++) sk_r[n] <= {DATA_W{1'b0}};
        end else if (adv_s) begin
          sk_r[0] <= b_beat_s[j];
          for (int n = 1; n < j; n++) sk_r[n] <= sk_r[n-1];
        end
      end
      assign b_skew_s[j] = sk_r[j-1];
    end
  end

  // PE grid: a_r/b_r/v_r hold the operand pair currently at the PE; it is
  // accumulated on the advancing edge and passed on at the same time.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [DATA_W-1:0] a_r, b_r, a_left_s, b_top_s;
      logic                     v_r, v_left_s;
      logic signed [ACC_W-1:0]  acc_r;

      if (j == 0) begin : g_aedge
        assign a_left_s = a_skew_s[i];
        assign v_left_s = v_skew_s[i];
      end else begin : g_aint
        assign a_left_s = a_pe_s[i][j-1];
        assign v_left_s = v_pe_s[i][j-1];
      end
      if (i == 0) begin : g_bedge
        assign b_top_s = b_skew_s[j];
      end else begin : g_bint
        assign b_top_s = b_pe_s[i-1][j];
      end

      assign a_pe_s[i][j] = a_r;
      assign b_pe_s[i][j] = b_r;
      assign v_pe_s[i][j] = v_r;
      assign acc_s[i][j]  = acc_r;

      // Operand pipeline: A moves right, B moves down, one PE per advance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= {DATA_W{1'b0}};
          b_r <= {DATA_W{1'b0}};
          v_r <= 1'b0;
        end else if (clr_s) begin
          a_r <= {DATA_W{1'b0}};
          b_r <= {DATA_W{1'b0}};
          v_r <= 1'b0;
        end else if (adv_s) begin
          a_r <= a_left_s;
          b_r <= b_top_s;
          v_r <= v_left_s;
        end
      end

`ifdef SYSTOLIC_SAT_EN
      logic                  sat_r;
      logic signed [ACC_W:0] sum_s;
      assign sum_s = mac_sum(acc_r, a_r, b_r);
      assign sat_flag[i*COLS+j] = sat_r;
      // Saturating accumulator; once clipped it holds for the rest of the tile.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_r <= {ACC_W{1'b0}};
          sat_r <= 1'b0;
        end else if (clr_s) begin
          acc_r <= {ACC_W{1'b0}};
          sat_r <= 1'b0;
        end else if (adv_s && v_r && !sat_r) begin
          if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            acc_r <= sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_r <= 1'b1;
          end else begin
            acc_r <= sum_s[ACC_W-1:0];
          end
        end
      end
`else
      // Wrapping accumulator, updated only by tagged (non-bubble) operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_r <= {ACC_W{1'b0}};
        end else if (clr_s) begin
          acc_r <= {ACC_W{1'b0}};
        end else if (adv_s && v_r) begin
          acc_r <= mac_wrap(acc_r, a_r, b_r);
        end
      end
`endif
    end
  end

  // Result row select for the current drain index; zero outside DRAIN.
  always_comb begin
    out_row = {(COLS*ACC_W){1'b0}};
    if (out_valid_r) begin
      for (int j = 0; j < COLS; j++) begin
        out_row[(j+1)*ACC_W-1 -: ACC_W] = acc_s[row_idx_r][j];
      end
    end else begin
      out_row = {(COLS*ACC_W){1'b0}};
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
module tb_systolic_array_os;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_W    = 9;

`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic [8:0]  k_len;
  logic [31:0] a_in_bus, b_in_bus;
  logic [63:0] out_row;
  logic [1:0]  out_row_idx;
  logic        out_last, busy, done;
`ifdef SYSTOLIC_SAT_EN
  logic [15:0] sat_flag;
`endif

  systolic_array_os #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in_bus(a_in_bus), .b_in_bus(b_in_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done)
`ifdef SYSTOLIC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0;
  logic [63:0] exp_rows [4];

  typedef struct {
    string name;
    int    k;
    int    a;
    int    b;
    bit    bub;
    int    stall;
    int    e;
    bit    sat;
    int    lat;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] beat_a(input int mode, input int av, input int k, input int i);
    if (mode == 1) return (i == k) ? 8'd1 : 8'd0;
    return 8'(av);
  endfunction

  function automatic logic [7:0] beat_b(input int mode, input int bv, input int k, input int j);
    if (mode == 1) return 8'(k + 1 + j);
    return 8'(bv);
  endfunction

  task automatic start_tile(input int k);
    @(negedge clk);
    t0    = cyc_cnt;
    start = 1'b1;
    k_len = 9'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = 9'd0;
  endtask

  task automatic feed(input int mode, input int av, input int bv, input int nbeats,
                      input bit bub, input bit chk_end);
    int beat  = 0;
    int guard = 0;
    bit tog   = 1'b1;
    while (beat < nbeats && guard < 100) begin
      in_valid = bub ? tog : 1'b1;
      for (int i = 0; i < 4; i++) begin
        a_in_bus[i*8 +: 8] = beat_a(mode, av, beat, i);
        b_in_bus[i*8 +: 8] = beat_b(mode, bv, beat, i);
      end
      if (in_valid && in_ready) beat++;
      tog = ~tog;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    a_in_bus = 32'd0;
    b_in_bus = 32'd0;
    chk("feed_beats_accepted", 80'(beat), 80'(nbeats));
    if (chk_end) chk("in_ready_drop", 80'(in_ready), 80'd0);
  endtask

  task automatic drain(input int stall, input int lat, input string nm);
    int w    = 0;
    bit seen = 1'b0;
    while (!out_valid && w < 1000) begin
      if (in_ready) seen = 1'b1;
      @(negedge clk);
      w++;
    end
    chk({nm, "_out_valid_rise"}, 80'(out_valid), 80'd1);
    chk({nm, "_no_ready_in_flush"}, 80'(seen), 80'd0);
    if (lat >= 0) chk({nm, "_latency"}, 80'(cyc_cnt - t0), 80'(lat));
    chk({nm, "_busy"}, 80'(busy), 80'd1);
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        chk($sformatf("%s_stall_r%0d_c%0d", nm, r, s), {out_valid, out_row_idx, out_row},
            {1'b1, 2'(r), exp_rows[r]});
        @(negedge clk);
      end
      out_ready = 1'b1;
      chk($sformatf("%s_row%0d", nm, r), {out_valid, out_row_idx, out_last, out_row},
          {1'b1, 2'(r), (r == 3), exp_rows[r]});
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk({nm, "_done_pulse"}, {out_valid, busy, done}, 80'b001);
    @(negedge clk);
    chk({nm, "_done_clear"}, {out_valid, busy, done}, 80'b000);
  endtask

  task automatic set_uniform(input int e);
    logic [15:0] e16;
    e16 = 16'(e);
    for (int r = 0; r < 4; r++) exp_rows[r] = {e16, e16, e16, e16};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"signed_bub", 3, -2, 5, 1'b1, 0, -30, 1'b0, -1};
    tbl[1] = '{"wrap127", 3, 127, 127, 1'b0, 0, (SAT ? 32767 : -17149), SAT, 11};
    tbl[2] = '{"kzero", 0, 9, 9, 1'b0, 1, 0, 1'b0, 8};
    tbl[3] = '{"neg_pos", 5, 3, -7, 1'b0, 2, -105, 1'b0, 13};
    tbl[4] = '{"minmin", 2, -128, -128, 1'b0, 0, (SAT ? 32767 : -32768), SAT, 10};
    tbl[5] = '{"minmax_bub", 2, -128, 127, 1'b1, 0, -32512, 1'b0, -1};
    tbl[6] = '{"minmax3", 3, -128, 127, 1'b0, 0, (SAT ? -32768 : 16768), SAT, 11};

    rst_n = 1'b0; start = 1'b0; k_len = 9'd0; in_valid = 1'b0;
    a_in_bus = 32'd0; b_in_bus = 32'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, busy, done, out_last, out_row_idx, out_row}, 80'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {in_ready, out_valid, busy, done}, 80'd0);

    for (int v = 0; v < 7; v++) begin
      start_tile(tbl[v].k);
      feed(0, tbl[v].a, tbl[v].b, tbl[v].k, tbl[v].bub, 1'b1);
      set_uniform(tbl[v].e);
      drain(tbl[v].stall, tbl[v].lat, tbl[v].name);
`ifdef SYSTOLIC_SAT_EN
      chk({tbl[v].name, "_sat_flag"}, 80'(sat_flag), tbl[v].sat ? 80'hFFFF : 80'd0);
`endif
    end

    // Identity tile with 5-cycle backpressure on every row.
    start_tile(4);
    feed(1, 0, 0, 4, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        exp_rows[r][j*16 +: 16] = 16'(r + 1 + j);
    drain(5, 12, "identity_bp");

    // Reset while loading beat 2, then a fresh tile.
    start_tile(4);
    feed(0, 7, 7, 2, 1'b0, 1'b0);
    chk("mid_load_busy", {busy, in_ready}, 80'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {in_ready, out_valid, busy, done, out_last, out_row_idx, out_row}, 80'd0);
`ifdef SYSTOLIC_SAT_EN
    chk("mid_reset_sat_flag", 80'(sat_flag), 80'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {in_ready, out_valid, busy, done}, 80'd0);
    start_tile(1);
    feed(0, 3, 3, 1, 1'b0, 1'b1);
    set_uniform(9);
    drain(0, 9, "after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
